// File: rtl/halfstrip_scanner.sv
// Half-strip pulse scanner: injects pulses per channel, counts misses (and crosstalk with HS_SCAN_XTALK_EN).
// Latency: pulse_en rises 2 cycles after start; per pulse W+D+2 cycles, +1 ARM cycle per channel.
// Backpressure: none; start ignored while busy, abort/reset return to IDLE the next cycle.
module halfstrip_scanner #(
    parameter int NHS  = 32,
    parameter int CNTW = 16,
    localparam int HSW = $clog2(NHS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [HSW-1:0]  first_hs,
    input  logic [HSW-1:0]  last_hs,
    input  logic [11:0]     num_pulses,
    input  logic [3:0]      pulse_width,
    input  logic [3:0]      bx_delay,
    input  logic [NHS-1:0]  halfstrips,
    output logic            pulse_en,
    output logic [HSW-1:0]  active_halfstrip,
    output logic            busy,
    output logic            done,
    input  logic [HSW-1:0]  rd_adr,
    output logic [CNTW-1:0] rd_err,
    output logic [CNTW-1:0] rd_xtalk
);

    typedef enum logic [2:0] {IDLE, ARM, PULSE, WAIT, CHECK, NEXT, DONE} state_t;

    localparam logic [HSW-1:0] HS_MAX = HSW'(NHS - 1);

    state_t          state;
    logic [HSW-1:0]  first_r, last_r;
    logic [11:0]     num_r, pcnt;
    logic [3:0]      pw_r, dly_r, tmr;
    logic            first_arm;

    logic [HSW-1:0]  last_clamp;
    logic [3:0]      pw_eff;
    logic            cnt_clr, cnt_upd, miss, rd_in_range;

    assign last_clamp  = ({1'b0, last_hs} >= (HSW+1)'(NHS)) ? HS_MAX : last_hs;
    assign pw_eff      = (pulse_width == 4'd0) ? 4'd1 : pulse_width;
    assign cnt_clr     = (state == ARM) && first_arm && !abort;
    assign cnt_upd     = (state == CHECK) && !abort;
    assign miss        = !halfstrips[active_halfstrip];
    assign rd_in_range = ({1'b0, rd_adr} < (HSW+1)'(NHS));

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            pulse_en         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            active_halfstrip <= '0;
            first_r          <= '0;
            last_r           <= '0;
            num_r            <= '0;
            pcnt             <= '0;
            pw_r             <= 4'd1;
            dly_r            <= '0;
            tmr              <= '0;
            first_arm        <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            pulse_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state            <= ARM;
                    busy             <= 1'b1;
                    first_r          <= first_hs;
                    last_r           <= last_clamp;
                    num_r            <= num_pulses;
                    pw_r             <= pw_eff;
                    dly_r            <= bx_delay;
                    active_halfstrip <= first_hs;
                    first_arm        <= 1'b1;
                end
                ARM: begin
                    first_arm <= 1'b0;
                    pcnt      <= '0;
                    if (first_r > last_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (num_r == 12'd0) begin
                        state <= NEXT;
                    end else begin
                        state    <= PULSE;
                        pulse_en <= 1'b1;
                        tmr      <= pw_r - 4'd1;
                    end
                end
                PULSE: begin
                    if (tmr == 4'd0) begin
                        pulse_en <= 1'b0;
                        if (dly_r == 4'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= WAIT;
                            tmr   <= dly_r - 4'd1;
                        end
                    end else begin
                        tmr <= tmr - 4'd1;
                    end
                end
                WAIT: begin
                    if (tmr == 4'd0) state <= CHECK;
                    else             tmr   <= tmr - 4'd1;
                end
                CHECK: state <= NEXT;
                NEXT: begin
                    if (pcnt + 12'd1 < num_r) begin
                        pcnt     <= pcnt + 12'd1;
                        state    <= PULSE;
                        pulse_en <= 1'b1;
                        tmr      <= pw_r - 4'd1;
                    end else if (active_halfstrip == last_r) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        active_halfstrip <= active_halfstrip + HSW'(1);
                        state            <= ARM;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    pulse_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Miss counters saturate at all-ones rather than wrapping.
    logic [CNTW-1:0] err_cnt [NHS];

    always_ff @(posedge clock) begin
        if (reset || cnt_clr) begin
            for (int i = 0; i < NHS; i++) err_cnt[i] <= '0;
        end else if (cnt_upd && miss && (err_cnt[active_halfstrip] != '1)) begin
            err_cnt[active_halfstrip] <= err_cnt[active_halfstrip] + CNTW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rd_err <= '0;
        else       rd_err <= rd_in_range ? err_cnt[rd_adr] : '0;
    end

`ifdef HS_SCAN_XTALK_EN
    logic [NHS-1:0]  others;
    logic [CNTW-1:0] xt_cnt [NHS];

    assign others = halfstrips & ~(NHS'(1) << active_halfstrip);

    always_ff @(posedge clock) begin
        if (reset || cnt_clr) begin
            for (int i = 0; i < NHS; i++) xt_cnt[i] <= '0;
        end else if (cnt_upd && (others != '0) && (xt_cnt[active_halfstrip] != '1)) begin
            xt_cnt[active_halfstrip] <= xt_cnt[active_halfstrip] + CNTW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rd_xtalk <= '0;
        else       rd_xtalk <= rd_in_range ? xt_cnt[rd_adr] : '0;
    end
`else
    assign rd_xtalk = '0;
`endif

endmodule

// File: tb/tb_halfstrip_scanner.sv
module tb_halfstrip_scanner;

    localparam int NHS = 32;
    localparam int HSW = 5;
`ifdef HS_SCAN_XTALK_EN
    localparam bit XT = 1'b1;
`else
    localparam bit XT = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset, start, abort;
    logic [HSW-1:0] first_hs, last_hs, rd_adr;
    logic [11:0]    num_pulses;
    logic [3:0]     pulse_width, bx_delay;
    logic [NHS-1:0] halfstrips, halfstrips_dead;
    logic           pulse_en, busy, done;
    logic [HSW-1:0] active_halfstrip;
    logic [15:0]    rd_err, rd_xtalk;
    logic           pulse_en2, busy2, done2;
    logic [HSW-1:0] active2;
    logic [3:0]     rd_err2, rd_xtalk2;

    int dead_ch = -1;
    int xt_ch   = -1;
    int n_vec   = 0;
    int n_miss  = 0;
    longint exp_q[$];
    string  tag_q[$];

    halfstrip_scanner #(.NHS(NHS), .CNTW(16)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .first_hs(first_hs), .last_hs(last_hs), .num_pulses(num_pulses),
        .pulse_width(pulse_width), .bx_delay(bx_delay), .halfstrips(halfstrips),
        .pulse_en(pulse_en), .active_halfstrip(active_halfstrip), .busy(busy),
        .done(done), .rd_adr(rd_adr), .rd_err(rd_err), .rd_xtalk(rd_xtalk)
    );

    // Narrow-counter twin fed with no hits at all, for saturation.
    halfstrip_scanner #(.NHS(NHS), .CNTW(4)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .first_hs(first_hs), .last_hs(last_hs), .num_pulses(num_pulses),
        .pulse_width(pulse_width), .bx_delay(bx_delay), .halfstrips(halfstrips_dead),
        .pulse_en(pulse_en2), .active_halfstrip(active2), .busy(busy2),
        .done(done2), .rd_adr(rd_adr), .rd_err(rd_err2), .rd_xtalk(rd_xtalk2)
    );

    assign halfstrips_dead = '0;

    always_comb begin
        halfstrips = '0;
        if (int'(active_halfstrip) != dead_ch) halfstrips[active_halfstrip] = 1'b1;
        if (int'(active_halfstrip) == xt_ch)   halfstrips[10] = 1'b1;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input longint v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input longint obs);
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else                   chk(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic rd_check(input int adr, input int e_err, input int e_xt, input int e_err2);
        @(negedge clock);
        rd_adr = HSW'(adr);
        sb_push($sformatf("rd_err[%0d]", adr), e_err);
        sb_push($sformatf("rd_xtalk[%0d]", adr), e_xt);
        sb_push($sformatf("sat_rd_err[%0d]", adr), e_err2);
        sb_push($sformatf("sat_rd_xtalk[%0d]", adr), 0);
        @(negedge clock);
        sb_pop(rd_err);
        sb_pop(rd_xtalk);
        sb_pop(rd_err2);
        sb_pop(rd_xtalk2);
    endtask

    task automatic run_scan(input int f, input int l, input int n, input int w, input int d);
        int  weff, nch, exp_done, k, first_pulse, plen;
        bit  seen, pend, got_done, pulses;
        weff     = (w == 0) ? 1 : w;
        nch      = (f > l) ? 0 : (l - f + 1);
        pulses   = (nch > 0) && (n > 0);
        exp_done = (nch == 0) ? 1 : ((n == 0) ? nch * 2 : nch * (n * (weff + d + 2) + 1));
        sb_push("done_cycle", exp_done);
        sb_push("pulse_seen", pulses);
        if (pulses) begin
            sb_push("first_pulse_cycle", 1);
            sb_push("pulse_len", weff);
        end
        @(negedge clock);
        first_hs = HSW'(f); last_hs = HSW'(l); num_pulses = 12'(n);
        pulse_width = 4'(w); bx_delay = 4'(d); start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // Inputs change after start; the scan must keep the captured values.
        first_hs = 5'd3; last_hs = 5'd4; num_pulses = 12'd1; pulse_width = 4'd9; bx_delay = 4'd9;
        k = 0; seen = 0; pend = 0; got_done = 0; first_pulse = -1; plen = 0;
        while (!got_done && k < 20000) begin
            if (pulse_en) begin
                if (!seen) begin seen = 1; first_pulse = k; end
                if (!pend) plen++;
            end else if (seen) begin
                pend = 1;
            end
            if (k == 1) chk("busy_in_scan", busy, 1);
            if (done) begin
                got_done = 1;
            end else begin
                start = (k == 20 && exp_done > 40);
                @(negedge clock);
                k++;
            end
        end
        start = 1'b0;
        sb_pop(got_done ? k : -1);
        sb_pop(seen);
        if (pulses) begin
            sb_pop(first_pulse);
            sb_pop(plen);
        end
        @(negedge clock);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit saw_done;
        reset = 1; start = 1; abort = 0; rd_adr = '0;
        first_hs = '0; last_hs = '0; num_pulses = '0; pulse_width = '0; bx_delay = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_pulse_en", pulse_en, 0);
        chk("rst_done", done, 0);
        chk("rst_active", active_halfstrip, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_rd_xtalk", rd_xtalk, 0);
        chk("rst_sat_busy", busy2 | pulse_en2 | done2, 0);
        chk("rst_sat_active", active2, 0);
        reset = 0; start = 0;
        @(negedge clock);
        chk("start_with_reset_ignored", busy, 0);

        // Full scan, every channel answers.
        run_scan(0, 31, 4, 2, 3);
        for (int a = 0; a < NHS; a++) rd_check(a, 0, 0, 4);

        // Channel 5 dead.
        dead_ch = 5;
        run_scan(0, 31, 10, 1, 0);
        for (int a = 0; a < NHS; a++) rd_check(a, (a == 5) ? 10 : 0, 0, 10);

        // Saturation on the 4-bit twin.
        dead_ch = -1;
        run_scan(2, 2, 20, 1, 0);
        rd_check(2, 0, 0, 15);
        rd_check(5, 0, 0, 0);

        // Empty range clears counters and never pulses.
        run_scan(7, 3, 4, 2, 3);
        rd_check(2, 0, 0, 0);

        // Zero pulses: ARM+NEXT per channel, nothing counted.
        dead_ch = 0;
        run_scan(0, 3, 0, 2, 2);
        rd_check(0, 0, 0, 0);

        // Crosstalk on channel 9 via bit 10.
        dead_ch = -1; xt_ch = 9;
        run_scan(9, 9, 3, 2, 1);
        rd_check(9, 0, XT ? 3 : 0, 3);
        rd_check(10, 0, 0, 0);
        xt_ch = -1;

        // Abort 3 cycles into the first pulse of channel 1.
        dead_ch = 0;
        @(negedge clock);
        first_hs = 5'd0; last_hs = 5'd31; num_pulses = 12'd4; pulse_width = 4'd6; bx_delay = 4'd1;
        start = 1;
        @(negedge clock);
        start = 0;
        k = 0;
        while (!(active_halfstrip == 5'd1 && pulse_en) && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("abort_reach_ch1", (k < 2000), 1);
        repeat (2) @(negedge clock);
        chk("abort_still_pulsing", pulse_en, 1);
        abort = 1;
        @(negedge clock);
        abort = 0;
        chk("abort_pulse_en", pulse_en, 0);
        chk("abort_busy", busy, 0);
        saw_done = 0;
        repeat (30) begin
            @(negedge clock);
            if (done || busy) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);
        rd_check(0, 4, 0, 4);
        rd_check(1, 0, 0, 0);

        // Reset mid-scan clears counters; start during reset ignored.
        @(negedge clock);
        first_hs = 5'd0; last_hs = 5'd1; num_pulses = 12'd2; pulse_width = 4'd1; bx_delay = 4'd0;
        start = 1;
        @(negedge clock);
        start = 0;
        k = 0;
        while (active_halfstrip != 5'd1 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("reset_reach_ch1", (k < 2000), 1);
        reset = 1; start = 1;
        @(negedge clock);
        reset = 0; start = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_pulse_en", pulse_en, 0);
        chk("midrst_active", active_halfstrip, 0);
        @(negedge clock);
        chk("midrst_start_ignored", busy, 0);
        rd_check(0, 0, 0, 0);
        dead_ch = -1;

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
